rnn: RTL and testbench

Memory-mapped single-layer Elman RNN cell accelerator with 4 hidden units and a scalar input, all values signed Q8.8. It sits as a slave on the system register bus. Software loads weights and biases, then writes one input sample per timestep. The block computes h ← hardtanh(W_x·x + W_h·h + b) with one sequential MAC and exposes the hidden state for readback.

---
 rtl/rnn.sv | 213 +++++++++++++++++++++
 tb/tb_rnn.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rnn.sv
// -----------------------------------------------------------------------------
// rnn -- memory-mapped Elman RNN cell accelerator (4 hidden units, scalar input,
// signed Q8.8 data). One timestep computes
//   h <= hardtanh(W_x*x + W_h*h + b)
// on a single sequential MAC: 5 MAC cycles per neuron, 20 in total, followed by
// one commit cycle. The write to X therefore has a 21-cycle latency to new h.
//
// Ports
//   clk       in   1   clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   read      in   1   bus read strobe (one cycle per access)
//   write     in   1   bus write strobe (one cycle per access, wins over read)
//   addr      in  32   word index, fully decoded
//   data_in   in  32   write data, bits [15:0] used
//   data_out  out 32   registered read data, 1-cycle latency, held between reads
//
// Register map (word addresses)
//   0      CTRL/STATUS  W: bit1 clears h and done   R: {30'b0, busy, done}
//   1      X            W: latch x and start a step R: sign-extended x
//   2..5   W_x[0..3]
//   6..21  W_h[i][j] at 6+4i+j
//   22..25 b[0..3]
//   26..29 h[0..3]      read-only
//   other  reads 0, writes ignored
// All writes are ignored while busy.
// -----------------------------------------------------------------------------
module rnn (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MAC    = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t             state_q;
  logic signed [15:0] wx_q [4];
  logic signed [15:0] wh_q [16];
  logic signed [15:0] b_q  [4];
  logic signed [15:0] h_q  [4];
  logic signed [15:0] hn_q [4];
  logic signed [15:0] x_q;
  logic               busy_q;
  logic               done_q;
  logic [31:0]        data_out_q;
  logic [1:0]         n_q;     // neuron being computed
  logic [2:0]         k_q;     // MAC step within the neuron, 0..4
  logic signed [39:0] acc_q;

  // MAC datapath signals
  logic [1:0]         kk_d;
  logic signed [15:0] mac_a_d;
  logic signed [15:0] mac_b_d;
  logic signed [31:0] prod_d;
  logic signed [39:0] acc_base_d;
  logic signed [39:0] acc_d;
  logic signed [39:0] shr_d;
  logic signed [15:0] clip_d;

  // Bus decode signals
  logic [1:0]         grp_idx_s;
  logic [3:0]         wh_idx_s;
  logic [31:0]        rd_data_s;
  logic               unused_s;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Every 4-word group (W_x, b, h) starts at an address with [1:0] == 2, so
  // subtracting 2 modulo 4 yields the element index; W_h starts at 6 (mod 16).
  assign grp_idx_s = addr[1:0] - 2'd2;
  assign wh_idx_s  = addr[3:0] - 4'd6;
  assign unused_s  = ^data_in[31:16];
  assign data_out  = data_out_q;

  // MAC operand selection, accumulate, and Q8.8 rounding/clip of the result
  always_comb begin
    kk_d = k_q[1:0] - 2'd1;   // k=1..4 -> h index 0..3
    if (k_q == 3'd0) begin
      mac_a_d    = wx_q[n_q];
      mac_b_d    = x_q;
      // bias in Q8.8 promoted to the Q16.16 accumulator scale
      acc_base_d = {{16{b_q[n_q][15]}}, b_q[n_q], 8'h00};
    end else begin
      mac_a_d    = wh_q[{n_q, kk_d}];
      mac_b_d    = h_q[kk_d];
      acc_base_d = acc_q;
    end
    prod_d = mac_a_d * mac_b_d;
    acc_d  = acc_base_d + $signed({{8{prod_d[31]}}, prod_d});
    shr_d  = acc_d >>> 8;     // floor back to Q8.8
    if (shr_d > 40'sd256) begin
      clip_d = 16'sh0100;
    end else if (shr_d < -40'sd256) begin
      clip_d = 16'shFF00;
    end else begin
      clip_d = shr_d[15:0];
    end
  end

  // Read-data multiplexer over the register map
  always_comb begin
    rd_data_s = 32'h0000_0000;
    if (addr == 32'd0) begin
      rd_data_s = {30'd0, busy_q, done_q};
    end else if (addr == 32'd1) begin
      rd_data_s = sext16(x_q);
    end else if ((addr >= 32'd2) && (addr <= 32'd5)) begin
      rd_data_s = sext16(wx_q[grp_idx_s]);
    end else if ((addr >= 32'd6) && (addr <= 32'd21)) begin
      rd_data_s = sext16(wh_q[wh_idx_s]);
    end else if ((addr >= 32'd22) && (addr <= 32'd25)) begin
      rd_data_s = sext16(b_q[grp_idx_s]);
    end else if ((addr >= 32'd26) && (addr <= 32'd29)) begin
      rd_data_s = sext16(h_q[grp_idx_s]);
    end else begin
      rd_data_s = 32'h0000_0000;
    end
  end

  // Control FSM, register file, MAC state and registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      x_q        <= 16'sh0000;
      n_q        <= 2'd0;
      k_q        <= 3'd0;
      acc_q      <= 40'sh0;
      data_out_q <= 32'h0000_0000;
      for (int j = 0; j < 4; j++) begin
        wx_q[j] <= 16'sh0000;
        b_q[j]  <= 16'sh0000;
        h_q[j]  <= 16'sh0000;
        hn_q[j] <= 16'sh0000;
      end
      for (int j = 0; j < 16; j++) begin
        wh_q[j] <= 16'sh0000;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
        end
        ST_MAC: begin
          acc_q <= acc_d;
          if (k_q == 3'd4) begin
            hn_q[n_q] <= clip_d;
            k_q       <= 3'd0;
            if (n_q == 2'd3) begin
              state_q <= ST_COMMIT;
            end else begin
              n_q <= n_q + 2'd1;
            end
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        ST_COMMIT: begin
          for (int j = 0; j < 4; j++) begin
            h_q[j] <= hn_q[j];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (write) begin
        // busy_q stays high through COMMIT, so a start on that edge is dropped
        if (!busy_q) begin
          if (addr == 32'd0) begin
            if (data_in[1]) begin
              for (int j = 0; j < 4; j++) begin
                h_q[j] <= 16'sh0000;
              end
              done_q <= 1'b0;
            end
          end else if (addr == 32'd1) begin
            x_q     <= data_in[15:0];
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            n_q     <= 2'd0;
            k_q     <= 3'd0;
            state_q <= ST_MAC;
          end else if ((addr >= 32'd2) && (addr <= 32'd5)) begin
            wx_q[grp_idx_s] <= data_in[15:0];
          end else if ((addr >= 32'd6) && (addr <= 32'd21)) begin
            wh_q[wh_idx_s] <= data_in[15:0];
          end else if ((addr >= 32'd22) && (addr <= 32'd25)) begin
            b_q[grp_idx_s] <= data_in[15:0];
          end
        end
      end else if (read) begin
        data_out_q <= rd_data_s;
      end
    end
  end

endmodule

// File: tb/tb_rnn.sv
// -----------------------------------------------------------------------------
// tb_rnn -- directed self-checking bench for the rnn accelerator.
// Inputs are driven on the falling edge; data_out is sampled 1 time unit after
// the rising edge that performs the read. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_rnn;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;

  int compared = 0;
  int mismatched = 0;

  rnn dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    write = 1'b1; addr = a; data_in = d;
    @(posedge clk);
    #1;
    write = 1'b0; addr = 32'h0; data_in = 32'h0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] v);
    @(negedge clk);
    read = 1'b1; addr = a;
    @(posedge clk);
    #1;
    read = 1'b0; addr = 32'h0;
    v = data_out;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_rd(a, v);
    check(tag, v, exp);
  endtask

  // Polls STATUS until done, bounded; a timeout shows up as a failed check.
  task automatic wait_done(input string tag);
    logic [31:0] v;
    v = 32'h0;
    for (int n = 0; (n < 40) && (v != 32'h1); n++) begin
      bus_rd(32'd0, v);
    end
    check(tag, v, 32'h1);
  endtask

  initial begin
    logic [31:0] v;

    // Reset values
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    rd_chk("rst_status", 32'd0,  32'h0);
    rd_chk("rst_x",      32'd1,  32'h0);
    rd_chk("rst_h0",     32'd26, 32'h0);
    rd_chk("rst_h1",     32'd27, 32'h0);
    rd_chk("rst_h2",     32'd28, 32'h0);
    rd_chk("rst_h3",     32'd29, 32'h0);
    rd_chk("rst_unmap",  32'd30, 32'h0);

    // Negative input: 1.0 * (-1/256) = -1/256, exact busy window
    bus_wr(32'd2, 32'h0000_0100);
    rd_chk("wx0_rb", 32'd2, 32'h0000_0100);
    bus_wr(32'd1, 32'h0000_FFFF);
    for (int c = 0; c < 21; c++) begin
      bus_rd(32'd0, v);
      check("busy_window", v, 32'h2);
    end
    rd_chk("neg_done", 32'd0, 32'h1);
    rd_chk("neg_h0", 32'd26, 32'hFFFF_FFFF);
    rd_chk("neg_h1", 32'd27, 32'h0);
    rd_chk("neg_h2", 32'd28, 32'h0);
    rd_chk("neg_h3", 32'd29, 32'h0);
    rd_chk("neg_x",  32'd1,  32'hFFFF_FFFF);

    // Saturation in both directions
    bus_wr(32'd2, 32'h0000_7FFF);
    bus_wr(32'd3, 32'h0000_8000);
    rd_chk("wx1_rb", 32'd3, 32'hFFFF_8000);
    bus_wr(32'd1, 32'h0000_7FFF);
    wait_done("sat_done");
    rd_chk("sat_h0", 32'd26, 32'h0000_0100);
    rd_chk("sat_h1", 32'd27, 32'hFFFF_FF00);
    rd_chk("sat_h2", 32'd28, 32'h0);

    // Recurrence: h0 = 0.25 + 0.5*h0_old
    bus_wr(32'd2, 32'h0);
    bus_wr(32'd3, 32'h0);
    bus_wr(32'd0, 32'h2);
    rd_chk("clr1_h0", 32'd26, 32'h0);
    rd_chk("clr1_status", 32'd0, 32'h0);
    bus_wr(32'd6,  32'h0000_0080);
    bus_wr(32'd22, 32'h0000_0040);
    rd_chk("wh00_rb", 32'd6,  32'h0000_0080);
    rd_chk("b0_rb",   32'd22, 32'h0000_0040);
    bus_wr(32'd1, 32'h0);
    wait_done("rec1_done");
    rd_chk("rec1_h0", 32'd26, 32'h0000_0040);
    bus_wr(32'd1, 32'h0);
    wait_done("rec2_done");
    rd_chk("rec2_h0", 32'd26, 32'h0000_0060);
    rd_chk("rec2_h1", 32'd27, 32'h0);

    // Busy lockout: writes to X, W_x[0] and CTRL clear during a step are dropped
    bus_wr(32'd1, 32'h0);
    bus_wr(32'd1, 32'h0000_0100);
    bus_wr(32'd2, 32'h0000_0200);
    bus_wr(32'd0, 32'h2);
    rd_chk("lock_busy", 32'd0, 32'h2);
    rd_chk("lock_old_h0", 32'd26, 32'h0000_0060);
    wait_done("lock_done");
    rd_chk("lock_h0",  32'd26, 32'h0000_0070);
    rd_chk("lock_x",   32'd1,  32'h0);
    rd_chk("lock_wx0", 32'd2,  32'h0);
    repeat (25) @(posedge clk);
    #1;
    rd_chk("lock_one_step", 32'd0, 32'h1);
    rd_chk("lock_h0_hold",  32'd26, 32'h0000_0070);

    // Clear after the step
    bus_wr(32'd0, 32'h2);
    rd_chk("clr_h0", 32'd26, 32'h0);
    rd_chk("clr_h1", 32'd27, 32'h0);
    rd_chk("clr_h2", 32'd28, 32'h0);
    rd_chk("clr_h3", 32'd29, 32'h0);
    rd_chk("clr_status", 32'd0, 32'h0);

    // Unmapped and read-only accesses
    bus_wr(32'h0000_0100, 32'h0000_1234);
    rd_chk("unmap_rd", 32'h0000_0100, 32'h0);
    bus_wr(32'h0000_0102, 32'h0000_1234);
    rd_chk("unmap_alias_wx0", 32'd2, 32'h0);
    bus_wr(32'd26, 32'h0000_1234);
    rd_chk("h_ro", 32'd26, 32'h0);
    rd_chk("unmap_wh00", 32'd6, 32'h0000_0080);
    rd_chk("unmap_b0", 32'd22, 32'h0000_0040);
    rd_chk("unmap_status", 32'd0, 32'h0);

    // Reset mid-step aborts and does not restart
    bus_wr(32'd2, 32'h0000_0100);
    bus_wr(32'd1, 32'h0000_0100);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    rd_chk("abort_status", 32'd0, 32'h0);
    rd_chk("abort_h0", 32'd26, 32'h0);
    rd_chk("abort_wx0", 32'd2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
